// File: rtl/testport_snoop.sv
// rtl/testport_snoop.sv - test-port store snooper with de-dup, byte swap, result FIFO and perf counters
module testport_snoop #(
    parameter logic [29:0] TEST_PORT  = 30'hFF,
    parameter logic [31:0] BEGIN_SYM  = 32'h00000168,
    parameter logic [31:0] END_SYM    = 32'hFFFFFD5D,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] addr,
    input  logic [31:0] data,
    input  logic        wen,
    input  logic        stall,
    input  logic        flush,
    input  logic        type_i,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [6:0]  out_idx,
    output logic        out_last,
    output logic        active,
    output logic        done,
    output logic        overflow,
    output logic [15:0] cycle_cnt,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt,
    output logic [15:0] branch_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

    state_t      state_q, state_d;
    logic        armed_q;
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic [6:0]  idx_q;
    logic        overflow_q;
    logic [15:0] cycle_q, stall_q, flush_q, branch_q;

    logic [31:0] mem_data_q [FIFO_DEPTH];
    logic [6:0]  mem_idx_q  [FIFO_DEPTH];
    logic        mem_last_q [FIFO_DEPTH];

    logic [31:0] swapped;
    logic        hit, is_empty, is_full, pop, push_req, push, in_active;

    assign swapped  = {data[7:0], data[15:8], data[23:16], data[31:24]};
    // armed drops for the whole wen burst, so a store held through a stall counts once
    assign hit      = wen & armed_q & (addr == TEST_PORT);
    assign is_empty = (wr_ptr_q == rd_ptr_q);
    assign is_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop      = ~is_empty & out_ready;
    assign in_active = (state_q == S_ACTIVE);
    assign push_req = in_active & hit;
    assign push     = push_req & (~is_full | pop);

    function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic en);
        return (en && c != 16'hFFFF) ? c + 16'd1 : c;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (hit && swapped == BEGIN_SYM) state_d = S_ACTIVE;
            S_ACTIVE: if (hit && swapped == END_SYM)   state_d = S_DONE;
            S_DONE:   state_d = S_DONE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        active = (state_q == S_ACTIVE);
        done   = (state_q == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            armed_q    <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            idx_q      <= '0;
            overflow_q <= 1'b0;
            cycle_q    <= '0;
            stall_q    <= '0;
            flush_q    <= '0;
            branch_q   <= '0;
        end else begin
            armed_q <= ~wen;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            // idx advances even on a dropped word so the consumer sees the gap
            if (push_req) idx_q <= idx_q + 7'd1;
            if (push_req && !push) overflow_q <= 1'b1;
            cycle_q  <= sat_inc(cycle_q,  in_active);
            stall_q  <= sat_inc(stall_q,  in_active & stall);
            flush_q  <= sat_inc(flush_q,  in_active & flush);
            branch_q <= sat_inc(branch_q, in_active & type_i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_data_q[wr_ptr_q[AW-1:0]] <= swapped;
            mem_idx_q[wr_ptr_q[AW-1:0]]  <= idx_q;
            mem_last_q[wr_ptr_q[AW-1:0]] <= (swapped == END_SYM);
        end
    end

    assign out_valid  = ~is_empty;
    assign out_data   = is_empty ? 32'd0 : mem_data_q[rd_ptr_q[AW-1:0]];
    assign out_idx    = is_empty ? 7'd0  : mem_idx_q[rd_ptr_q[AW-1:0]];
    assign out_last   = is_empty ? 1'b0  : mem_last_q[rd_ptr_q[AW-1:0]];
    assign overflow   = overflow_q;
    assign cycle_cnt  = cycle_q;
    assign stall_cnt  = stall_q;
    assign flush_cnt  = flush_q;
    assign branch_cnt = branch_q;

endmodule

// File: tb/tb_testport_snoop.sv
// tb/tb_testport_snoop.sv - randomized and directed bench for testport_snoop against a queue-based model
module tb_testport_snoop;

    localparam logic [29:0] TP     = 30'hFF;
    localparam logic [31:0] BEG    = 32'h00000168;
    localparam logic [31:0] ENDS   = 32'hFFFFFD5D;
    localparam logic [31:0] BEG_LE = 32'h68010000;
    localparam logic [31:0] END_LE = 32'h5DFDFFFF;

    logic        clk = 1'b0;
    logic        rst, wen, stall, flush, type_i, out_ready;
    logic [29:0] addr;
    logic [31:0] data;
    logic        out_valid, out_last, active, done, overflow;
    logic [31:0] out_data;
    logic [6:0]  out_idx;
    logic [15:0] cycle_cnt, stall_cnt, flush_cnt, branch_cnt;

    always #5 clk = ~clk;

    testport_snoop dut (
        .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen),
        .stall(stall), .flush(flush), .type_i(type_i),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .active(active), .done(done),
        .overflow(overflow), .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt), .branch_cnt(branch_cnt)
    );

    typedef struct {
        int          idx;
        logic [31:0] d;
        bit          last;
    } ent_t;

    ent_t q[$];
    int   m_mode;   // 0 idle, 1 active, 2 done
    bit   m_armed, m_ovf;
    int   m_idx, m_cyc, m_stl, m_fl, m_br;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] readable(input logic [31:0] le);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*(3-b) +: 8] = le[8*b +: 8];
        return r;
    endfunction

    function automatic int sat(input int c, input bit en);
        return (en && c < 65535) ? c + 1 : c;
    endfunction

    task automatic model_reset();
        q.delete();
        m_mode = 0; m_armed = 1; m_ovf = 0; m_idx = 0;
        m_cyc = 0; m_stl = 0; m_fl = 0; m_br = 0;
    endtask

    task automatic compare_all();
        check("out_valid", 32'(out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            check("out_data", out_data, q[0].d);
            check("out_idx", 32'(out_idx), 32'(q[0].idx));
            check("out_last", 32'(out_last), 32'(q[0].last));
        end else begin
            check("out_data_empty", out_data, 32'd0);
            check("out_idx_empty", 32'(out_idx), 32'd0);
            check("out_last_empty", 32'(out_last), 32'd0);
        end
        check("active", 32'(active), 32'(m_mode == 1));
        check("done", 32'(done), 32'(m_mode == 2));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("cycle_cnt", 32'(cycle_cnt), 32'(m_cyc));
        check("stall_cnt", 32'(stall_cnt), 32'(m_stl));
        check("flush_cnt", 32'(flush_cnt), 32'(m_fl));
        check("branch_cnt", 32'(branch_cnt), 32'(m_br));
    endtask

    // One clock: the model consumes the inputs seen at this edge, then all outputs are compared.
    task automatic step();
        bit          ev, pop;
        logic [31:0] sw;
        sw  = readable(data);
        ev  = wen && m_armed && (addr == TP);
        pop = (q.size() > 0) && out_ready;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (m_mode == 1) begin
                m_cyc = sat(m_cyc, 1);
                m_stl = sat(m_stl, stall);
                m_fl  = sat(m_fl, flush);
                m_br  = sat(m_br, type_i);
            end
            if (pop) void'(q.pop_front());
            if (m_mode == 0 && ev && sw == BEG) begin
                m_mode = 1;
            end else if (m_mode == 1 && ev) begin
                if (q.size() < 4) q.push_back('{idx: m_idx, d: sw, last: (sw == ENDS)});
                else m_ovf = 1;
                m_idx = (m_idx + 1) % 128;
                if (sw == ENDS) m_mode = 2;
            end
            m_armed = !wen;
        end
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        rst = 0; wen = 0; stall = 0; flush = 0; type_i = 0;
        addr = '0; data = '0;
    endtask

    task automatic do_reset();
        rst = 1; step(); rst = 0;
    endtask

    task automatic store(input logic [29:0] a, input logic [31:0] d, input int hold);
        addr = a; data = d; wen = 1;
        for (int i = 0; i < hold; i++) step();
        wen = 0; step();
    endtask

    initial begin
        idle_inputs();
        out_ready = 0;
        model_reset();
        do_reset();
        do_reset();

        // begin word opens the window without being queued
        store(TP, BEG_LE, 1);
        check("begin_active", 32'(active), 32'd1);
        check("begin_no_entry", 32'(out_valid), 32'd0);
        store(TP, 32'h01000000, 1);
        check("first_data", out_data, 32'h00000001);
        check("first_idx", 32'(out_idx), 32'd0);

        // stall de-dup: held store yields one entry, re-assert yields another
        store(TP, 32'hAABBCCDD, 4);
        store(TP, 32'hAABBCCDD, 1);
        store(30'h12, 32'h11111111, 1);
        store(TP, 32'h22222222, 1);
        store(TP, 32'h33333333, 1);
        check("ovf_set", 32'(overflow), 32'd1);
        out_ready = 1;
        for (int i = 0; i < 6; i++) step();
        out_ready = 0;

        // push and pop together at full
        do_reset();
        store(TP, BEG_LE, 1);
        for (int i = 0; i < 4; i++) store(TP, 32'h10 + i, 1);
        addr = TP; data = 32'h0000BEEF; wen = 1; out_ready = 1; step();
        wen = 0; out_ready = 0; step();
        check("full_pushpop_ovf", 32'(overflow), 32'd0);

        // counters
        out_ready = 1;
        stall = 1; for (int i = 0; i < 10; i++) step(); stall = 0;
        flush = 1; for (int i = 0; i < 3; i++) step();  flush = 0;
        type_i = 1; for (int i = 0; i < 5; i++) step(); type_i = 0;
        check("stall10", 32'(stall_cnt), 32'd10);
        check("flush3", 32'(flush_cnt), 32'd3);
        check("branch5", 32'(branch_cnt), 32'd5);

        // end symbol, later store ignored
        out_ready = 0;
        store(TP, END_LE, 1);
        check("end_done", 32'(done), 32'd1);
        store(TP, 32'h44444444, 1);
        out_ready = 1;
        for (int i = 0; i < 4; i++) step();

        // reset mid-run with entries queued
        do_reset();
        out_ready = 0;
        store(TP, BEG_LE, 1);
        store(TP, 32'h01020304, 1);
        store(TP, 32'h05060708, 1);
        do_reset();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_active", 32'(active), 32'd0);

        // randomized episodes
        for (int ep = 0; ep < 12; ep++) begin
            int rdy_pct;
            rdy_pct = $urandom_range(10, 100);
            idle_inputs();
            do_reset();
            for (int c = 0; c < 400; c++) begin
                int r;
                rst    = ($urandom_range(0, 299) == 0);
                wen    = ($urandom_range(0, 2) == 0) ? ~wen : wen;
                addr   = ($urandom_range(0, 3) == 0) ? 30'($urandom) : TP;
                r      = $urandom_range(0, 15);
                data   = (r < 2) ? BEG_LE : (r == 2 && c > 150) ? END_LE : $urandom;
                stall  = $urandom_range(0, 1);
                flush  = ($urandom_range(0, 3) == 0);
                type_i = ($urandom_range(0, 2) == 0);
                out_ready = ($urandom_range(1, 100) <= rdy_pct);
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
